// File: rtl/branch_pkg.sv
// Shared encodings and the condition evaluator for the branch unit.
// Pure definitions: no state, no latency, no flow control.
package branch_pkg;

  localparam logic [2:0] BR_STEP  = 3'd0;
  localparam logic [2:0] BR_JMP   = 3'd1;
  localparam logic [2:0] BR_JCC   = 3'd2;
  localparam logic [2:0] BR_JR    = 3'd3;
  localparam logic [2:0] BR_CALL  = 3'd4;
  localparam logic [2:0] BR_CALLR = 3'd5;
  localparam logic [2:0] BR_RET   = 3'd6;

  localparam logic [2:0] CC_EQ     = 3'd0;
  localparam logic [2:0] CC_NE     = 3'd1;
  localparam logic [2:0] CC_LT     = 3'd2;
  localparam logic [2:0] CC_GE     = 3'd3;
  localparam logic [2:0] CC_GT     = 3'd4;
  localparam logic [2:0] CC_LE     = 3'd5;
  localparam logic [2:0] CC_ALWAYS = 3'd6;
  localparam logic [2:0] CC_NEVER  = 3'd7;

  localparam int unsigned BR_RESET_VEC = 0;

  function automatic logic cond_holds(input logic [2:0] cc, input logic eq, input logic lt);
    logic res;
    res = 1'b0;
    case (cc)
      CC_EQ:     res = eq;
      CC_NE:     res = !eq;
      CC_LT:     res = lt;
      CC_GE:     res = !lt;
      CC_GT:     res = !lt && !eq;
      CC_LE:     res = lt || eq;
      CC_ALWAYS: res = 1'b1;
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; a push at full overwrites the oldest entry and sets sticky ovf.
// One-edge update, rdata shows the current top combinationally; never stalls.
module ras_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [PTR_W-1:0] rd_idx;

  // top_q is the next free slot; the newest entry sits just below it.
  assign rd_idx = top_q - PTR_W'(1);
  assign rdata  = mem_q[rd_idx];
  assign count  = count_q;
  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign ovf    = ovf_q;

  always_comb begin
    mem_d   = mem_q;
    top_d   = top_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push) begin
      mem_d[top_q] = wdata;
      top_d        = top_q + PTR_W'(1);
      if (full) ovf_d = 1'b1;
      else      count_d = count_q + CNT_W'(1);
    end else if (pop && !empty) begin
      top_d   = rd_idx;
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      top_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/branch_unit.sv
// Program counter with jump, conditional branch, indirect, call and return resolution.
// One-edge latency from req to addr/taken/fault; accepts a request every cycle, no backpressure.
module branch_unit
  import branch_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter int          IMM_W     = 26,
  parameter int          RAS_DEPTH = 8,
  parameter int unsigned RESET_VEC = BR_RESET_VEC
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req,
  input  logic [2:0]                     op,
  input  logic [2:0]                     cond,
  input  logic [IMM_W-1:0]               imm,
  input  logic [ADDR_W-1:0]              rtarget,
  input  logic                           cmp_valid,
  input  logic [DATA_W-1:0]              cmp_a,
  input  logic [DATA_W-1:0]              cmp_b,
  output logic [ADDR_W-1:0]              addr,
  output logic                           taken,
  output logic                           fault,
  output logic                           ras_ovf,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_empty,
  output logic                           ras_full
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              taken_q, taken_d;
  logic              fault_q, fault_d;
  logic              eq_q, eq_d;
  logic              lt_q, lt_d;
  logic [ADDR_W-1:0] seq;
  logic [ADDR_W-1:0] jt;
  logic              ras_push;
  logic              ras_pop;
  logic [ADDR_W-1:0] ras_rdata;

  assign seq = addr_q + ADDR_W'(4);
  assign jt  = ADDR_W'({imm, 2'b00});

  ras_stack #(
    .DEPTH(RAS_DEPTH),
    .W    (ADDR_W)
  ) u_ras (
    .clk  (clk),
    .reset(reset),
    .push (ras_push),
    .pop  (ras_pop),
    .wdata(seq),
    .rdata(ras_rdata),
    .count(ras_count),
    .full (ras_full),
    .empty(ras_empty),
    .ovf  (ras_ovf)
  );

  // Flags captured this cycle only become visible to JCC on the next cycle.
  always_comb begin
    eq_d = eq_q;
    lt_d = lt_q;
    if (cmp_valid) begin
      eq_d = (cmp_a == cmp_b);
      lt_d = ($signed(cmp_a) < $signed(cmp_b));
    end
  end

  always_comb begin
    addr_d   = addr_q;
    taken_d  = 1'b0;
    fault_d  = 1'b0;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (req) begin
      addr_d = seq;
      case (op)
        BR_JMP: begin
          addr_d  = jt;
          taken_d = 1'b1;
        end
        BR_JCC: begin
          if (cond_holds(cond, eq_q, lt_q)) begin
            addr_d  = jt;
            taken_d = 1'b1;
          end
        end
        BR_JR: begin
          addr_d  = rtarget;
          taken_d = 1'b1;
        end
        BR_CALL: begin
          ras_push = 1'b1;
          addr_d   = jt;
          taken_d  = 1'b1;
        end
        BR_CALLR: begin
          ras_push = 1'b1;
          addr_d   = rtarget;
          taken_d  = 1'b1;
        end
        BR_RET: begin
          if (ras_empty) begin
            fault_d = 1'b1;
          end else begin
            ras_pop = 1'b1;
            addr_d  = ras_rdata;
            taken_d = 1'b1;
          end
        end
        default: addr_d = seq;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= ADDR_W'(RESET_VEC);
      taken_q <= 1'b0;
      fault_q <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      taken_q <= taken_d;
      fault_q <= fault_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end

  assign addr  = addr_q;
  assign taken = taken_q;
  assign fault = fault_q;

endmodule

// File: doc/branch_unit.md
# branch_unit

Parametrised program-counter and branch-resolution block for the next-generation processor core. It sits between the controller and the instruction address bus and owns `addr`. It resolves unconditional, conditional, register-indirect, call and return transfers. Compare flags and a circular return-address stack of configurable depth are held internally, so nested calls survive without controller involvement.

## Interface
- `ADDR_W`, 32: program-counter and target width.
- `DATA_W`, 32: compare operand width.
- `IMM_W`, 26: jump immediate width; target is the immediate shifted left 2.
- `RAS_DEPTH`, 8: return-address stack entries, ≥2, power of two.
- `RESET_VEC`, 0: program-counter value after reset.

- `clk`, in, 1: clock; all state updates on rising edge.
- `reset`, in, 1: synchronous, active-high.
- `req`, in, 1: one-cycle strobe; perform `op` this edge.
- `op`, in, 3: 0 STEP, 1 JMP, 2 JCC, 3 JR, 4 CALL, 5 CALLR, 6 RET, 7 reserved (acts as STEP).
- `cond`, in, 3: JCC condition. 0 EQ, 1 NE, 2 LT, 3 GE, 4 GT, 5 LE (signed), 6 ALWAYS, 7 NEVER.
- `imm`, in, IMM_W: immediate for JMP/JCC/CALL.
- `rtarget`, in, ADDR_W: register target for JR/CALLR; used unaligned.
- `cmp_valid`, in, 1: capture flags from `cmp_a`/`cmp_b`.
- `cmp_a`, `cmp_b`, in, DATA_W: compare operands, signed.
- `addr`, out, ADDR_W: current program counter (registered).
- `taken`, out, 1: registered pulse; the last request redirected flow.
- `fault`, out, 1: registered pulse; RET issued with stack empty.
- `ras_ovf`, out, 1: sticky; a push overwrote the oldest entry.
- `ras_count`, out, $clog2(RAS_DEPTH+1): live entries.
- `ras_empty`, `ras_full`, out, 1: stack status.

## Operation
- `seq` = `addr` + 4, truncated to ADDR_W. `jt` = zero-extended `imm` << 2, truncated to ADDR_W.
- STEP: `addr` ← `seq`.
- JMP: `addr` ← `jt`; `taken` = 1.
- JCC: if the condition holds on the registered flags, `addr` ← `jt` and `taken` = 1. Otherwise `addr` ← `seq`.
- JR: `addr` ← `rtarget`; `taken` = 1.
- CALL and CALLR: push `seq`. `addr` ← `jt` (CALL) or `rtarget` (CALLR); `taken` = 1.
- RET, stack not empty: pop; `addr` ← popped value; `taken` = 1.
- RET, stack empty: `addr` ← `seq`; `fault` = 1; stack unchanged.
- Flags: `eq` = (`cmp_a` == `cmp_b`), `lt` = signed(`cmp_a`) < signed(`cmp_b`). They are registered on `cmp_valid` and hold otherwise.
- Conditions: EQ = eq; NE = !eq; LT = lt; GE = !lt; GT = !lt & !eq; LE = lt | eq.
- Stack is circular: `top` pointer plus `count`.
  - Push at full writes over the oldest slot. `count` stays at RAS_DEPTH and `ras_ovf` is set.
  - After such an overflow, RAS_DEPTH pops return the newest RAS_DEPTH addresses.
- When `req` = 0: `addr`, stack and `count` hold; `taken` and `fault` are 0.

## Timing
- Reset values:
  - `addr` = RESET_VEC.
  - `taken`, `fault`, `ras_ovf` = 0.
  - `ras_count` = 0, `ras_empty` = 1, `ras_full` = 0.
  - Flags `eq` = `lt` = 0, so GT holds after reset.
  - Stack contents are don't-care.
- Latency: one edge. `addr` reflects a request from the following edge.
- `cmp_valid` and JCC in the same cycle: JCC uses the old flags. New flags are visible from the next cycle.
- Reset asserted in the same cycle as `req` or `cmp_valid`: reset wins, and the request is discarded. The stack is emptied and pending flags are lost.
- `ras_count`, `ras_full`, `ras_empty` are registered. They are consistent with `addr` in the same cycle.
- Back-to-back requests on every edge are legal; there are no stall conditions.

## Structure
- Shared package `branch_pkg`:
  - op encodings (`BR_STEP` … `BR_RET`).
  - cond encodings (`CC_EQ` … `CC_NEVER`).
  - reset-vector default.
- Sub-module `ras_stack` holds the circular stack, `top`, `count` and overflow tracking.
  - Parameters: DEPTH, W.
  - Ports: `push`, `pop`, `wdata`, `rdata`, `count`, `full`, `empty`, `ovf`.
- PC select, flags and the condition evaluator stay in `branch_unit`.
- Expected size is about 220 RTL lines total.

## Test plan
- Reset, then four STEPs → `addr` goes 0, 4, 8, C, 10.
- JMP `imm`=0x3AF0397 → `addr`=0x0EBC0E5C, `taken`=1.
- Compare and branch on flags:
  - `cmp` 33 vs 51, then JCC LT `imm`=0xB7421E → `addr`=0x02DD0878.
  - Then `cmp` 51 vs 33, JCC LT → `addr`=0x02DD087C, `taken`=0.
  - Same cycle: `cmp` 5 vs 5 with JCC EQ → old flags used (not taken). The next JCC EQ is taken.
- Call and return:
  - At `addr`=0x0C270C6C, CALLR `rtarget`=0x54BBE901 → `addr`=0x54BBE901, `ras_count`=1.
  - Two STEPs, then RET → `addr`=0x0C270C70, `ras_empty`=1.
- Overflow, RAS_DEPTH=8:
  - Nine CALLs → `ras_ovf`=1, `ras_full`=1, `ras_count`=8.
  - Eight RETs return calls 9…2 in reverse order.
  - A ninth RET → `fault`=1 and `addr` = previous + 4.
- Reset mid-sequence with three entries and `cmp_valid` high → `addr`=RESET_VEC, `ras_count`=0, flags cleared. The next RET faults, and JCC GT is taken.
